// File: rtl/operand_sel_rr.sv
// ---------------------------------------------------------------------------
// operand_sel_rr
//
// N_IN-way, WIDTH-bit operand selector with a single registered output stage
// and valid/ready handshakes on every port. The channel is picked either by
// an explicit select (mode 0) or by a round-robin arbiter (mode 1). The
// output holds steady under backpressure and carries the index of the
// channel that produced it.
//
// Ports:
//   clk_i    in   clock, rising edge
//   rst_ni   in   synchronous active-low reset
//   data_i   in   N_IN*WIDTH, channel k at [k*WIDTH +: WIDTH]
//   valid_i  in   N_IN, per-channel valid
//   ready_o  out  N_IN, per-channel ready (combinational)
//   sel_i    in   SEL_W, explicit select used in mode 0
//   mode_i   in   0 = explicit select, 1 = round-robin
//   data_o   out  WIDTH, registered selected operand
//   valid_o  out  data_o holds an unconsumed operand
//   ready_i  in   downstream accepts data_o
//   src_o    out  SEL_W, channel that produced data_o
//   err_o    out  one-cycle pulse: out-of-range sel_i during an attempt
// ---------------------------------------------------------------------------
module operand_sel_rr #(
  parameter int WIDTH = 8,
  parameter int N_IN  = 4,
  parameter int SEL_W = $clog2(N_IN)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [N_IN*WIDTH-1:0]   data_i,
  input  logic [N_IN-1:0]         valid_i,
  output logic [N_IN-1:0]         ready_o,
  input  logic [SEL_W-1:0]        sel_i,
  input  logic                    mode_i,
  output logic [WIDTH-1:0]        data_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [SEL_W-1:0]        src_o,
  output logic                    err_o
);

  typedef enum logic {
    MODE_EXPLICIT = 1'b0,
    MODE_RR       = 1'b1
  } mode_e;

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_IN - 1);
  localparam logic [SEL_W:0]   N_IN_W  = (SEL_W + 1)'(N_IN);

  mode_e             mode;
  logic              space;
  logic              sel_legal;
  logic              grant_ok;
  logic              load;
  logic              err_d;
  logic              rr_found;
  logic [SEL_W-1:0]  rr_idx;
  logic [SEL_W-1:0]  chosen;
  logic [SEL_W-1:0]  ptr_q;
  logic [SEL_W-1:0]  ptr_next;
  logic [SEL_W:0]    sum;
  logic [SEL_W-1:0]  cand;
  logic [WIDTH-1:0]  ch_data;

  assign mode      = mode_e'(mode_i);
  // The stage can accept a new operand when it is empty or being drained.
  assign space     = !valid_o || ready_i;
  assign sel_legal = (sel_i <= LAST_CH);

  // Round-robin scan starting at ptr_q. The sum is one bit wider than the
  // pointer so that ptr + i (at most 2*N_IN-2) never overflows before the
  // modulo-N_IN correction; ptr therefore never reaches a value >= N_IN.
  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = ptr_q;
    sum      = '0;
    cand     = '0;
    for (int i = 0; i < N_IN; i++) begin
      sum = {1'b0, ptr_q} + (SEL_W + 1)'(i);
      if (sum >= N_IN_W) sum = sum - N_IN_W;
      cand = sum[SEL_W-1:0];
      if (!rr_found && valid_i[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  assign chosen   = (mode == MODE_RR) ? rr_idx : sel_i;
  assign grant_ok = (mode == MODE_RR) ? rr_found : sel_legal;
  assign ptr_next = (rr_idx == LAST_CH) ? '0 : rr_idx + SEL_W'(1);

  // In explicit mode ready does not look at valid_i; in round-robin mode it
  // goes only to the channel the arbiter picked.
  always_comb begin
    ready_o = '0;
    for (int k = 0; k < N_IN; k++) begin
      ready_o[k] = space && grant_ok && (chosen == SEL_W'(k));
    end
  end

  always_comb begin
    ch_data = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (chosen == SEL_W'(k)) ch_data = data_i[k*WIDTH +: WIDTH];
    end
  end

  assign load  = |(valid_i & ready_o);
  assign err_d = (mode == MODE_EXPLICIT) && !sel_legal && space && (|valid_i);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      src_o   <= '0;
      err_o   <= 1'b0;
      ptr_q   <= '0;
    end else begin
      err_o <= err_d;
      if (load) begin
        // Covers both an empty stage and consume-and-reload with no bubble.
        valid_o <= 1'b1;
        data_o  <= ch_data;
        src_o   <= chosen;
        if (mode == MODE_RR) ptr_q <= ptr_next;
      end else if (ready_i) begin
        // Drained with nothing new: data_o/src_o keep their last values.
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_operand_sel_rr.sv
// ---------------------------------------------------------------------------
// tb_operand_sel_rr
//
// Directed bench for operand_sel_rr. A 4-channel instance covers explicit
// select, backpressure, round-robin fairness, skip/wrap, mid-operation reset
// and mode switching; a 3-channel instance covers the out-of-range select
// error pulse and modulo-3 pointer wrap.
// ---------------------------------------------------------------------------
module tb_operand_sel_rr;

  logic clk;
  logic rst_n;

  // 4-channel instance
  logic [31:0] data4;
  logic [3:0]  valid4;
  logic [3:0]  ready_o4;
  logic [1:0]  sel4;
  logic        mode4;
  logic [7:0]  data_o4;
  logic        valid_o4;
  logic        ready_i4;
  logic [1:0]  src_o4;
  logic        err_o4;

  // 3-channel instance
  logic [23:0] data3;
  logic [2:0]  valid3;
  logic [2:0]  ready_o3;
  logic [1:0]  sel3;
  logic        mode3;
  logic [7:0]  data_o3;
  logic        valid_o3;
  logic        ready_i3;
  logic [1:0]  src_o3;
  logic        err_o3;

  int checks = 0;
  int errors = 0;

  operand_sel_rr #(.WIDTH(8), .N_IN(4)) u_dut4 (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .data_i  (data4),
    .valid_i (valid4),
    .ready_o (ready_o4),
    .sel_i   (sel4),
    .mode_i  (mode4),
    .data_o  (data_o4),
    .valid_o (valid_o4),
    .ready_i (ready_i4),
    .src_o   (src_o4),
    .err_o   (err_o4)
  );

  operand_sel_rr #(.WIDTH(8), .N_IN(3)) u_dut3 (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .data_i  (data3),
    .valid_i (valid3),
    .ready_o (ready_o3),
    .sel_i   (sel3),
    .mode_i  (mode3),
    .data_o  (data_o3),
    .valid_o (valid_o3),
    .ready_i (ready_i3),
    .src_o   (src_o3),
    .err_o   (err_o3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out4(input string tag, input logic v, input logic [7:0] d,
                            input logic [1:0] s);
    check({tag, ".valid"}, 32'(valid_o4), 32'(v));
    check({tag, ".data"},  32'(data_o4),  32'(d));
    check({tag, ".src"},   32'(src_o4),   32'(s));
  endtask

  task automatic check_out3(input string tag, input logic v, input logic [7:0] d,
                            input logic [1:0] s);
    check({tag, ".valid"}, 32'(valid_o3), 32'(v));
    check({tag, ".data"},  32'(data_o3),  32'(d));
    check({tag, ".src"},   32'(src_o3),   32'(s));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset and explicit select ----------------
    rst_n    = 1'b0;
    mode4    = 1'b0;
    sel4     = 2'd2;
    valid4   = 4'b0100;
    data4    = 32'h00A5_0000;
    ready_i4 = 1'b1;
    mode3    = 1'b0;
    sel3     = 2'd0;
    valid3   = 3'b000;
    data3    = 24'h33_2211;
    ready_i3 = 1'b1;

    for (int c = 0; c < 2; c++) begin
      tick();
      check_out4("reset4", 1'b0, 8'h00, 2'd0);
      check("reset4.err",   32'(err_o4),   32'd0);
      check("reset4.ready", 32'(ready_o4), 32'b0100);
      check_out3("reset3", 1'b0, 8'h00, 2'd0);
      check("reset3.err",   32'(err_o3),   32'd0);
    end
    rst_n = 1'b1;
    #1 check("sel.ready_pre", 32'(ready_o4), 32'b0100);
    tick();
    check_out4("sel.first", 1'b1, 8'hA5, 2'd2);
    check("sel.ready_post", 32'(ready_o4), 32'b0100);

    // ---------------- backpressure hold ----------------
    ready_i4 = 1'b0;
    data4    = 32'h003C_0000;
    #1 check("bp.ready", 32'(ready_o4), 32'b0000);
    for (int c = 0; c < 3; c++) begin
      tick();
      check_out4("bp.hold", 1'b1, 8'hA5, 2'd2);
      check("bp.ready_hold", 32'(ready_o4), 32'b0000);
    end
    ready_i4 = 1'b1;
    #1 check("bp.release_ready", 32'(ready_o4), 32'b0100);
    tick();
    check_out4("bp.nobubble", 1'b1, 8'h3C, 2'd2);

    // Drain with no new transfer: data/src retained.
    valid4 = 4'b0000;
    tick();
    check_out4("drain", 1'b0, 8'h3C, 2'd2);

    // ---------------- round-robin fairness ----------------
    mode4  = 1'b1;
    valid4 = 4'b1111;
    data4  = 32'h1312_1110;
    #1 check("rr.ready0", 32'(ready_o4), 32'b0001);
    for (int i = 0; i < 8; i++) begin
      tick();
      check_out4("rr.fair", 1'b1, 8'(8'h10 + (i % 4)), 2'(i % 4));
      check("rr.ready", 32'(ready_o4), 32'(4'b0001 << ((i + 1) % 4)));
    end

    // ---------------- round-robin skip and wrap ----------------
    valid4 = 4'b0100;
    #1 check("wrap.ready_ch2", 32'(ready_o4), 32'b0100);
    tick();
    check_out4("wrap.ch2", 1'b1, 8'h12, 2'd2);
    valid4 = 4'b0011;
    #1 check("wrap.ready_ch0", 32'(ready_o4), 32'b0001);
    tick();
    check_out4("wrap.ch0", 1'b1, 8'h10, 2'd0);
    check("wrap.ready_ch1", 32'(ready_o4), 32'b0010);
    tick();
    check_out4("wrap.ch1", 1'b1, 8'h11, 2'd1);
    valid4 = 4'b1111;
    #1 check("wrap.ptr_is_2", 32'(ready_o4), 32'b0100);

    // ---------------- reset mid-operation ----------------
    ready_i4 = 1'b0;
    #1 check("mid.ready_bp", 32'(ready_o4), 32'b0000);
    tick();
    check_out4("mid.pending", 1'b1, 8'h11, 2'd1);
    rst_n = 1'b0;
    tick();
    check_out4("mid.reset", 1'b0, 8'h00, 2'd0);
    rst_n = 1'b1;
    #1 check("mid.ptr_zero", 32'(ready_o4), 32'b0001);

    // ---------------- mode switch with pending output ----------------
    tick();
    check_out4("sw.load", 1'b1, 8'h10, 2'd0);
    mode4 = 1'b0;
    sel4  = 2'd3;
    #1 check("sw.ready_m0", 32'(ready_o4), 32'b0000);
    tick();
    check_out4("sw.hold_m0", 1'b1, 8'h10, 2'd0);
    mode4 = 1'b1;
    tick();
    check_out4("sw.hold_m1", 1'b1, 8'h10, 2'd0);
    ready_i4 = 1'b1;
    #1 check("sw.ptr_kept", 32'(ready_o4), 32'b0010);
    tick();
    check_out4("sw.next", 1'b1, 8'h11, 2'd1);

    // ---------------- illegal select (N_IN = 3) ----------------
    sel3   = 2'd3;
    valid3 = 3'b111;
    #1 check("ill.ready", 32'(ready_o3), 32'b000);
    tick();
    check("ill.err_pulse", 32'(err_o3), 32'd1);
    check("ill.valid", 32'(valid_o3), 32'd0);
    sel3 = 2'd1;
    #1 check("ill.ready_sel1", 32'(ready_o3), 32'b010);
    tick();
    check("ill.err_clear", 32'(err_o3), 32'd0);
    check_out3("ill.sel1", 1'b1, 8'h22, 2'd1);

    // Out-of-range select under backpressure: no attempt, no error.
    ready_i3 = 1'b0;
    sel3     = 2'd3;
    tick();
    check("ill.err_bp", 32'(err_o3), 32'd0);
    check_out3("ill.hold", 1'b1, 8'h22, 2'd1);

    // Out-of-range select with no valid input: no error.
    ready_i3 = 1'b1;
    valid3   = 3'b000;
    tick();
    check("ill.err_novalid", 32'(err_o3), 32'd0);
    check("ill.drained", 32'(valid_o3), 32'd0);

    // ---------------- modulo-3 pointer wrap ----------------
    mode3  = 1'b1;
    valid3 = 3'b111;
    #1 check("rr3.ready0", 32'(ready_o3), 32'b001);
    tick();
    check_out3("rr3.g0", 1'b1, 8'h11, 2'd0);
    tick();
    check_out3("rr3.g1", 1'b1, 8'h22, 2'd1);
    tick();
    check_out3("rr3.g2", 1'b1, 8'h33, 2'd2);
    check("rr3.ptr_wrap", 32'(ready_o3), 32'b001);
    tick();
    check_out3("rr3.g3", 1'b1, 8'h11, 2'd0);
    check("rr3.err", 32'(err_o3), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_sel_rr.md
# operand_sel_rr

Parametrised N-way, WIDTH-bit operand selector with one registered output stage and valid/ready handshakes on every port. It supersedes the fixed 2:1 instruction-memory/register-B operand mux in the datapath. Any number of operand sources can feed the ALU operand path under an explicit select or a round-robin arbitration mode. Output is held stable under backpressure and tagged with the source channel.

## Interface
Parameters:
- WIDTH, 8, data width of every channel and of the output
- N_IN, 4, number of input channels (legal range 2..16)
- SEL_W, $clog2(N_IN), derived; width of select and source tag (do not override)

Ports:
- clk_i  input  1  clock; all state updates on rising edge
- rst_ni  input  1  reset, synchronous, active-low
- data_i  input  N_IN*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- valid_i  input  N_IN  per-channel valid
- ready_o  output  N_IN  per-channel ready; combinational
- sel_i  input  SEL_W  explicit channel select (mode 0)
- mode_i  input  1  0 = explicit select, 1 = round-robin
- data_o  output  WIDTH  registered selected operand
- valid_o  output  1  data_o holds an unconsumed operand
- ready_i  input  1  downstream accepts data_o
- src_o  output  SEL_W  channel index that produced data_o
- err_o  output  1  one-cycle registered pulse: sel_i ≥ N_IN while its transfer was attempted

## Operation
- Clock is clk_i; reset is synchronous, active-low on rst_ni.
- space = !valid_o || ready_i. The stage loads only when space = 1.
- Mode 0 (explicit):
  - chosen = sel_i.
  - ready_o[k] = space && (k == sel_i) && (sel_i < N_IN). It does not depend on valid_i.
  - Transfer happens on channel k when valid_i[k] && ready_o[k].
- Mode 0, sel_i ≥ N_IN:
  - All ready_o = 0 and nothing loads.
  - err_o = 1 next cycle if space = 1 and any valid_i is high that cycle; otherwise err_o = 0.
- Mode 1 (round-robin):
  - Internal pointer ptr is SEL_W bits.
  - chosen is the first k with valid_i[k] = 1, scanning ptr, ptr+1, … N_IN-1, 0, … ptr-1.
  - ready_o[chosen] = space; all other ready_o = 0. If no valid_i is high, all ready_o = 0.
  - ready_o depends on valid_i in this mode. Upstream must not make valid_i depend on ready_o.
- On transfer:
  - data_o ← data_i[chosen], src_o ← chosen, valid_o ← 1.
  - In mode 1 only, ptr ← chosen+1, wrapping N_IN-1 → 0.
- Output consumed with no new transfer (valid_o && ready_i, and no channel transfers): valid_o ← 0. data_o and src_o keep their last values.
- Consume and load in the same cycle: the new operand replaces the old one with valid_o staying 1. No bubble.
- Backpressure (valid_o && !ready_i): data_o, src_o and valid_o are held. All ready_o = 0.
- mode_i and sel_i are sampled every cycle.
  - ptr is not modified by mode-0 transfers or by mode changes.
  - Switching mode never disturbs a pending output.
- ptr arithmetic is modulo N_IN, not modulo 2^SEL_W. It never holds a value ≥ N_IN.

## Timing
- Reset values (rst_ni = 0 at a rising edge): valid_o = 0, data_o = 0, src_o = 0, err_o = 0, ptr = 0.
- During reset, ready_o follows the combinational rules with valid_o = 0, so space = 1. Downstream ignores them.
- Reset mid-operation: a pending output is discarded, not delivered.
- Latency: 1 cycle from an input transfer edge to valid_o/data_o.
- Throughput: 1 operand per cycle while ready_i = 1.
- err_o is high for exactly one cycle per offending cycle. It is not sticky.
- No combinational path from data_i to data_o.
- Combinational paths exist from ready_i to ready_o, and from valid_i to ready_o (mode 1 only).

## Test plan
- Reset and explicit select:
  - Stimulus: N_IN=4, WIDTH=8. Hold rst_ni=0 for 2 cycles. Then mode 0, sel_i=2, valid_i=4'b0100, data ch2=8'hA5, ready_i=1.
  - Response: all outputs 0 while in reset. One cycle later valid_o=1, data_o=A5, src_o=2. ready_o = 4'b0100 throughout.
- Backpressure hold:
  - Stimulus: as above, ready_i=0 for 3 cycles while ch2 data changes to 8'h3C.
  - Response: data_o stays A5 and ready_o=0. On ready_i=1, data_o=3C on the next cycle with no bubble cycle.
- Round-robin fairness:
  - Stimulus: mode 1, all valid_i=1, data ch k = 8'h10+k, ready_i=1 for 8 cycles.
  - Response: src_o sequence 0,1,2,3,0,1,2,3 with matching data 10..13.
- Round-robin skip and wrap:
  - Stimulus: mode 1, ptr=3 after a grant to ch2, valid_i=4'b0011.
  - Response: ch0 is granted, then ch1. src_o = 0, 1 and ptr ends at 2.
- Illegal select:
  - Stimulus: N_IN=3, mode 0, sel_i=3, valid_i=3'b111, empty stage.
  - Response: ready_o=0 and valid_o stays 0. err_o=1 exactly one cycle later, then 0 once sel_i=1.
- Reset mid-operation and mode switch:
  - Stimulus: output pending with ready_i=0, then rst_ni=0 for one cycle.
  - Response: valid_o=0 and ptr=0 next cycle. A subsequent mode 0→1 switch while an operand is pending keeps data_o/src_o unchanged.
